// File: rtl/fe_fifo_reader_usb_if.sv
// fe_fifo_reader_usb_if: sniff-FIFO read port plus event stream.
// master is the reader block, slave is the FIFO/consumer side.
interface fe_fifo_reader_usb_if #(
  parameter int pTIME_ACC_WIDTH = 32
);
  logic                       I_fifo_empty;
  logic                       O_fifo_rd;
  logic [17:0]                I_fifo_dout;
  logic                       O_evt_valid;
  logic                       I_evt_ready;
  logic [1:0]                 O_evt_cmd;
  logic [7:0]                 O_evt_data;
  logic [4:0]                 O_evt_status;
  logic [pTIME_ACC_WIDTH-1:0] O_evt_time;

  modport master (
    input  I_fifo_empty,
    input  I_fifo_dout,
    input  I_evt_ready,
    output O_fifo_rd,
    output O_evt_valid,
    output O_evt_cmd,
    output O_evt_data,
    output O_evt_status,
    output O_evt_time
  );

  modport slave (
    output I_fifo_empty,
    output I_fifo_dout,
    output I_evt_ready,
    input  O_fifo_rd,
    input  O_evt_valid,
    input  O_evt_cmd,
    input  O_evt_data,
    input  O_evt_status,
    input  O_evt_time
  );
endinterface

// File: rtl/fe_fifo_reader_usb.sv
// fe_fifo_reader_usb: drains the USB sniff FIFO, rebuilds absolute
// timestamps and emits DATA/STAT events on a valid/ready stream.
module fe_fifo_reader_usb #(
  parameter int pTIME_ACC_WIDTH       = 32,
  parameter int pTIMESTAMP_FULL_WIDTH = 16
) (
  input  logic                 cwusb_clk,
  input  logic                 reset_n,
  input  logic                 I_clear,
  fe_fifo_reader_usb_if.master bus,
  output logic                 O_err_badcmd,
  output logic                 O_time_wrap
);

  localparam int AW = pTIME_ACC_WIDTH;
  localparam int FW = pTIMESTAMP_FULL_WIDTH;

  localparam logic [1:0] CMD_DATA = 2'b00;
  localparam logic [1:0] CMD_TIME = 2'b01;
  localparam logic [1:0] CMD_STAT = 2'b10;

  typedef enum logic {
    IDLE,
    FETCH
  } state_t;

  state_t state_q;
  state_t state_d;

  logic          fifo_rd;
  logic          fetch;

  logic [1:0]    cmd;
  logic [2:0]    short_t;
  logic [FW-1:0] full_t;
  logic [7:0]    data;
  logic [4:0]    status;

  logic          is_data;
  logic          is_time;
  logic          is_stat;
  logic          is_rsvd;

  logic [FW-1:0] delta;
  logic [AW-1:0] acc_q;
  logic [AW-1:0] acc_next;
  logic          carry;

  logic          valid_q;
  logic [1:0]    cmd_q;
  logic [7:0]    data_q;
  logic [4:0]    status_q;
  logic [AW-1:0] time_q;
  logic          badcmd_q;
  logic          wrap_q;

  assign cmd     = bus.I_fifo_dout[1:0];
  assign short_t = bus.I_fifo_dout[4:2];
  assign full_t  = bus.I_fifo_dout[FW+1:2];
  assign data    = bus.I_fifo_dout[12:5];
  assign status  = bus.I_fifo_dout[17:13];

  assign fetch = (state_q == FETCH);

  always_comb begin
    is_data = 1'b0;
    is_time = 1'b0;
    is_stat = 1'b0;
    is_rsvd = 1'b0;
    unique case (1'b1)
      (cmd == CMD_DATA): is_data = 1'b1;
      (cmd == CMD_TIME): is_time = 1'b1;
      (cmd == CMD_STAT): is_stat = 1'b1;
      default:           is_rsvd = 1'b1;
    endcase
  end

  always_comb begin
    delta = FW'(short_t);
    if (is_time) begin
      delta = full_t;
    end
    {carry, acc_next} = {1'b0, acc_q} + (AW+1)'(delta);
  end

  // state register
  always_ff @(posedge cwusb_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    if (I_clear) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:    if (fifo_rd) state_d = FETCH;
        FETCH:   state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // read strobe; held low in reset so an asserted reset_n
  // never lets a read escape while the FIFO is non-empty
  always_comb begin
    fifo_rd = 1'b0;
    if (state_q == IDLE && reset_n && !I_clear) begin
      fifo_rd = !bus.I_fifo_empty &&
                (!valid_q || bus.I_evt_ready);
    end
  end

  always_ff @(posedge cwusb_clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_q    <= '0;
      valid_q  <= 1'b0;
      cmd_q    <= '0;
      data_q   <= '0;
      status_q <= '0;
      time_q   <= '0;
      badcmd_q <= 1'b0;
      wrap_q   <= 1'b0;
    end else if (I_clear) begin
      acc_q    <= '0;
      valid_q  <= 1'b0;
      cmd_q    <= '0;
      data_q   <= '0;
      status_q <= '0;
      time_q   <= '0;
      badcmd_q <= 1'b0;
      wrap_q   <= 1'b0;
    end else begin
      if (valid_q && bus.I_evt_ready) begin
        valid_q <= 1'b0;
      end
      if (fetch) begin
        if (!is_rsvd) begin
          acc_q <= acc_next;
          if (carry) begin
            wrap_q <= 1'b1;
          end
        end
        // a read only issues when the slot is free, so
        // loading here never overwrites an unaccepted event
        if (is_data || is_stat) begin
          valid_q  <= 1'b1;
          cmd_q    <= cmd;
          data_q   <= is_stat ? 8'h00 : data;
          status_q <= status;
          time_q   <= acc_next;
        end
        if (is_rsvd) begin
          badcmd_q <= 1'b1;
        end
      end
    end
  end

  assign bus.O_fifo_rd    = fifo_rd;
  assign bus.O_evt_valid  = valid_q;
  assign bus.O_evt_cmd    = cmd_q;
  assign bus.O_evt_data   = data_q;
  assign bus.O_evt_status = status_q;
  assign bus.O_evt_time   = time_q;
  assign O_err_badcmd     = badcmd_q;
  assign O_time_wrap      = wrap_q;

endmodule

// File: doc/fe_fifo_reader_usb.md
# fe_fifo_reader_usb

Read-side counterpart of the USB front-end capture path. It drains 18-bit entries from the sniff FIFO in the `cwusb_clk` domain and decodes the DATA, STAT and TIME commands. It accumulates the per-entry time deltas into an absolute timestamp and presents each DATA/STAT event on a valid/ready stream to the USB readback logic. TIME entries are consumed internally and never emitted.

## Interface
- `pTIME_ACC_WIDTH`, 32: width of the absolute timestamp accumulator.
- `pTIMESTAMP_FULL_WIDTH`, 16: width of a TIME-entry delta; equals `FE_FIFO_FULLTIME_LEN`.

Ports:
- `cwusb_clk`  in  1  sole clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `I_clear`  in  1  synchronous clear; same effect as reset.
- `I_fifo_empty`  in  1  FIFO empty flag.
- `O_fifo_rd`  out  1  FIFO read strobe; data returns one cycle later.
- `I_fifo_dout`  in  18  FIFO entry.
- `O_evt_valid`  out  1  event available.
- `I_evt_ready`  in  1  consumer accepts the event.
- `O_evt_cmd`  out  2  `FE_FIFO_CMD_DATA` or `FE_FIFO_CMD_STAT`.
- `O_evt_data`  out  8  data byte; 0 for STAT events.
- `O_evt_status`  out  5  rxactive, rxerror, sessvld, sessend and vbusvld bits, in `defines_usb.v` order.
- `O_evt_time`  out  `pTIME_ACC_WIDTH`  absolute timestamp of the event.
- `O_err_badcmd`  out  1  sticky; set when a reserved command is decoded.
- `O_time_wrap`  out  1  sticky; set when the accumulator wraps.

## Operation
Entry layout:
- cmd = [1:0].
- Short time = [4:2].
- Full time = [17:2].
- Data = [12:5].
- Status = [17:13].

Command values:
- DATA = 2'b00.
- TIME = 2'b01.
- STAT = 2'b10.
- 2'b11 is reserved.

Time semantics:
- Every entry's time field is the tick count elapsed since the previous entry.
- TIME uses the 16-bit full field; DATA and STAT use the 3-bit short field, zero-extended.

FSM, two states:
- IDLE:
  - `O_fifo_rd` = !`I_fifo_empty` && (!`O_evt_valid` || `I_evt_ready`). This is the only combinational output.
  - If `O_fifo_rd` is asserted, go to FETCH.
- FETCH: `I_fifo_dout` is valid this cycle. Set `acc_next` = acc + delta, computed modulo 2^`pTIME_ACC_WIDTH`, then act on cmd:
  - DATA: register cmd, data, status and `acc_next` into the outputs; set `O_evt_valid`.
  - STAT: as DATA, but force `O_evt_data` to 0.
  - TIME: update the accumulator only; emit nothing.
  - Reserved: set `O_err_badcmd`; leave the accumulator unchanged; emit nothing.
  - Always return to IDLE.

Handshake and flags:
- Output registers are held stable while `O_evt_valid` && !`I_evt_ready`.
- `O_evt_valid` clears on a handshake unless it is reloaded in the same cycle.
- When the carry out of the accumulator add is 1, set `O_time_wrap`. Both sticky flags clear only on reset or `I_clear`.

`I_clear`:
- Zeroes the accumulator and both flags.
- Drops any pending output event.
- Forces IDLE. An entry returned from a read issued the previous cycle is discarded.
- Has priority over all other activity.

Reset values:
- `O_fifo_rd` 0.
- `O_evt_valid` 0.
- `O_evt_cmd`, `O_evt_data`, `O_evt_status` and `O_evt_time` all 0.
- Both flags 0; accumulator 0; state IDLE.

## Timing
- Read strobe in cycle N; decode in N+1; `O_evt_valid` and the event fields are visible from N+2.
- Peak throughput is one entry per 2 cycles. The next read may be issued in N+2 when `I_evt_ready`=1 in that cycle.
- FIFO empty: `O_fifo_rd` stays 0 and the FSM stays in IDLE. The block never reads an empty FIFO.
- Back-pressure: while `O_evt_valid`=1 and `I_evt_ready`=0, no read is issued. At most one event is buffered, and no entry is lost.
- A TIME entry followed by DATA: the DATA event's timestamp includes both deltas.
- Reset asserted mid-FETCH: the entry is lost and all outputs go to their reset values immediately (asynchronous).

## Test plan
- Reset, then one entry 0x074AC (DATA, time 3, data 0xA5, status 5'b00011), ready held high -> one read; two cycles later `O_evt_valid`=1, cmd 0, data 0xA5, status 3, time 3.
- TIME entry 0x048D1 (delta 0x1234), then DATA entry with short time 2 -> exactly one event, time 0x1236; no event emitted for the TIME entry.
- STAT entry whose data bits are nonzero -> `O_evt_data`=0 and status passed through unchanged.
- Hold ready=0 for 10 cycles with 3 entries queued -> exactly one read issued, outputs stable. After ready rises, the remaining entries are emitted in order and none are dropped.
- Reserved entry 0x00003 between two DATA entries with time 1 -> `O_err_badcmd`=1, two events with times 1 and 2.
- `pTIME_ACC_WIDTH`=16 with accumulator 0xFFFF, then DATA entry with time 2 -> time 0x0001 and `O_time_wrap`=1. A following `I_clear` clears the flag and accumulator, and drops the pending event.
